// File: rtl/alveo_hls4ml_mac_pipe.sv
// alveo_hls4ml_mac_pipe
// Pipelined signed multiply-accumulate over groups delimited by in_last.
// At group end a scaled (arithmetic right shift), width-reduced result is
// emitted with a one-cycle out_valid pulse, together with the beat count.
// Optional feature macro: MAC_SATURATE_EN
//   defined   -> shifted sum is clamped to the OUT_WIDTH signed range and
//                out_sat flags the clamp
//   undefined -> shifted sum wraps to OUT_WIDTH bits and out_sat is tied 0
module alveo_hls4ml_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 14,
    parameter int NUM_STAGE = 3,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_SHIFT = 0,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam int P = A_WIDTH + B_WIDTH;

    // Stage 1 operands, stage 2..NUM_STAGE products
    logic signed [A_WIDTH-1:0] a_q;
    logic signed [B_WIDTH-1:0] b_q;
    logic signed [P-1:0]       prod_q [2:NUM_STAGE];

    // Valid/last flags, bit s belongs to stage s
    logic [NUM_STAGE:1] vld_q;
    logic [NUM_STAGE:1] lst_q;

    // Accumulator state and next-state terms
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic [CNT_WIDTH-1:0]        cnt_q;
    logic [CNT_WIDTH-1:0]        cnt_next;
    logic [OUT_WIDTH-1:0]        result;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
    logic result_sat;
`endif

    // Flag pipeline: flags reset so in-flight beats are discarded on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (ce) begin
            vld_q <= {vld_q[NUM_STAGE-1:1], in_valid};
            lst_q <= {lst_q[NUM_STAGE-1:1], in_valid & in_last};
        end
    end

    // Data pipeline: operand capture, full-precision product, pure delay
    always_ff @(posedge clk) begin
        if (ce) begin
            a_q       <= a;
            b_q       <= b;
            prod_q[2] <= P'(a_q) * P'(b_q);
            for (int unsigned s = 3; s <= NUM_STAGE; s++) begin
                prod_q[s] <= prod_q[s-1];
            end
        end
    end

    // Next accumulator/count values and the scaled, width-reduced result
    always_comb begin
        acc_next = acc_q + ACC_WIDTH'(prod_q[NUM_STAGE]);
        cnt_next = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
        shifted  = acc_next >>> OUT_SHIFT;
`ifdef MAC_SATURATE_EN
        result_sat = 1'b0;
        result     = OUT_WIDTH'(shifted);
        if (shifted > SAT_MAX) begin
            result     = OUT_WIDTH'(SAT_MAX);
            result_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            result     = OUT_WIDTH'(SAT_MIN);
            result_sat = 1'b1;
        end
`else
        result = OUT_WIDTH'(shifted);
`endif
    end

    // Accumulate valid beats; on the last beat publish the result and clear
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
`ifdef MAC_SATURATE_EN
            out_sat   <= 1'b0;
`endif
        end else begin
            // pulse clears on every edge, independent of ce
            out_valid <= 1'b0;
            if (ce && vld_q[NUM_STAGE]) begin
                if (lst_q[NUM_STAGE]) begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    out_count <= cnt_next;
`ifdef MAC_SATURATE_EN
                    out_sat   <= result_sat;
`endif
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end else begin
                    acc_q     <= acc_next;
                    cnt_q     <= cnt_next;
                end
            end
        end
    end

`ifndef MAC_SATURATE_EN
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_alveo_hls4ml_mac_pipe.sv
// Testbench for alveo_hls4ml_mac_pipe: three instances (default, 16-bit
// output, shift of 4) share one stimulus stream; a queue-based group model
// predicts every output on every cycle, and directed groups pin literals.
module tb_alveo_hls4ml_mac_pipe;

    localparam int NS  = 3;
    localparam int ACC = 40;

    logic clk = 1'b0;
    logic reset, ce, in_valid, in_last;
    logic signed [15:0] a;
    logic signed [13:0] b;

    logic               v32, s32, v16, s16, v4, s4;
    logic signed [31:0] d32, d4;
    logic signed [15:0] d16;
    logic [7:0]         c32, c16, c4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alveo_hls4ml_mac_pipe dut32 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .out_valid(v32), .out_data(d32), .out_sat(s32), .out_count(c32));

    alveo_hls4ml_mac_pipe #(.OUT_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .out_valid(v16), .out_data(d16), .out_sat(s16), .out_count(c16));

    alveo_hls4ml_mac_pipe #(.OUT_SHIFT(4)) dut4 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .out_valid(v4), .out_data(d4), .out_sat(s4), .out_count(c4));

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor shift then reduce to w bits (clamp or wrap depending on build)
    function automatic longint reduce(input longint s, input int sh, input int w,
                                      output bit sat);
        longint t, one, hi, lo;
        one = 1;
        t   = s >>> sh;
        hi  = (one <<< (w-1)) - 1;
        lo  = -hi - 1;
        sat = 1'b0;
`ifdef MAC_SATURATE_EN
        if (t > hi) begin sat = 1'b1; return hi; end
        if (t < lo) begin sat = 1'b1; return lo; end
        return t;
`else
        return (t <<< (64-w)) >>> (64-w);
`endif
    endfunction

    function automatic longint wrap_acc(input longint v);
        return (v <<< (64-ACC)) >>> (64-ACC);
    endfunction

    function automatic int sat_cnt(input int c);
        return (c > 255) ? 255 : c;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { longint sum; int cnt; longint due; } res_t;
    res_t   pend[$];
    longint en_edges = 0;
    longint msum = 0;
    int     mcnt = 0;
    bit     exp_v = 1'b0;
    longint held_sum = 0;
    int     held_cnt = 0;
    int     cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        exp_v = 1'b0;
        if (reset) begin
            pend.delete();
            msum = 0;
            mcnt = 0;
            held_sum = 0;
            held_cnt = 0;
        end else if (ce) begin
            en_edges++;
            if (in_valid) begin
                msum = wrap_acc(msum + longint'(a) * longint'(b));
                mcnt++;
                if (in_last) begin
                    pend.push_back('{sum: msum, cnt: mcnt, due: en_edges + NS});
                    msum = 0;
                    mcnt = 0;
                end
            end
            if (pend.size() > 0 && pend[0].due == en_edges) begin
                exp_v    = 1'b1;
                held_sum = pend[0].sum;
                held_cnt = pend[0].cnt;
                void'(pend.pop_front());
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    initial forever begin
        longint e;
        bit     es;
        @(negedge clk);
        if (cyc > 0) begin
            chk("valid32", v32, exp_v);
            chk("valid16", v16, exp_v);
            chk("valid4",  v4,  exp_v);
            e = reduce(held_sum, 0, 32, es);
            chk("data32", d32, e);
            chk("sat32",  s32, es);
            e = reduce(held_sum, 0, 16, es);
            chk("data16", d16, e);
            chk("sat16",  s16, es);
            e = reduce(held_sum, 4, 32, es);
            chk("data4",  d4, e);
            chk("sat4",   s4, es);
            chk("count32", c32, sat_cnt(held_cnt));
            chk("count16", c16, sat_cnt(held_cnt));
            chk("count4",  c4,  sat_cnt(held_cnt));
        end
    end

    // ---------------- capture of result pulses ----------------
    typedef struct { int cyc; longint d32; longint d16; longint d4; int c32; bit s16; } cap_t;
    cap_t cap[$];

    initial forever begin
        @(negedge clk);
        if (v32) cap.push_back('{cyc: cyc, d32: longint'(d32), d16: longint'(d16),
                                  d4: longint'(d4), c32: int'(c32), s16: s16});
    end

    // ---------------- stimulus ----------------
    int last_edge = 0;

    task automatic step(input int av, input int bv, input bit vv, input bit lv);
        a        = 16'(av);
        b        = 14'(bv);
        in_valid = vv;
        in_last  = lv;
        @(posedge clk);
        #2;
        if (vv && lv) last_edge = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit     ps;
        longint pv;
        int     e1;

        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0;
        @(posedge clk); #2;
        idle(2);
        chk("reset_valid", v32, 0);
        chk("reset_data",  d32, 0);
        chk("reset_count", c32, 0);
        reset = 1'b0;
        idle(1);

        // model pins
        pv = reduce(-21, 4, 32, ps);
        chk("pin_floor", pv, -2);
        pv = reduce(536788994, 0, 16, ps);
`ifdef MAC_SATURATE_EN
        chk("pin_clamp", pv, 32767);
        chk("pin_clamp_flag", ps, 1);
`else
        chk("pin_wrap", pv, -16382);
        chk("pin_wrap_flag", ps, 0);
`endif

        // single beat
        cap.delete();
        step(3, -5, 1'b1, 1'b1);
        e1 = last_edge;
        idle(8);
        chk("single_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("single_data", cap[0].d32, -15);
            chk("single_cnt",  cap[0].c32, 1);
            chk("single_lat",  cap[0].cyc, e1 + NS);
        end

        // group with a bubble, then a back-to-back one-beat group
        cap.delete();
        step(100, 200, 1'b1, 1'b0);
        step(100, 200, 1'b1, 1'b0);
        idle(1);
        step(100, 200, 1'b1, 1'b0);
        step(100, 200, 1'b1, 1'b1);
        e1 = last_edge;
        step(1, 1, 1'b1, 1'b1);
        idle(8);
        chk("bubble_n", cap.size(), 2);
        if (cap.size() > 1) begin
            chk("bubble_data", cap[0].d32, 80000);
            chk("bubble_cnt",  cap[0].c32, 4);
            chk("bubble_cyc",  cap[0].cyc, e1 + NS);
            chk("next_data",   cap[1].d32, 1);
            chk("next_cnt",    cap[1].c32, 1);
            chk("next_cyc",    cap[1].cyc, e1 + NS + 1);
        end

        // ce stall of 5 cycles while the last beat sits in stage 2
        cap.delete();
        step(6, -7, 1'b1, 1'b1);
        e1 = last_edge;
        idle(1);
        ce = 1'b0;
        idle(5);
        ce = 1'b1;
        idle(12);
        chk("stall_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("stall_data", cap[0].d32, -42);
            chk("stall_cyc",  cap[0].cyc, e1 + NS + 5);
        end

        // 16-bit output reduction
        cap.delete();
        step(32767, 8191, 1'b1, 1'b0);
        step(32767, 8191, 1'b1, 1'b1);
        idle(8);
        chk("wide_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("wide_data32", cap[0].d32, 536788994);
`ifdef MAC_SATURATE_EN
            chk("wide_data16", cap[0].d16, 32767);
            chk("wide_sat16",  cap[0].s16, 1);
`else
            chk("wide_data16", cap[0].d16, -16382);
            chk("wide_sat16",  cap[0].s16, 0);
`endif
        end

        // floor shift
        cap.delete();
        step(-7, 3, 1'b1, 1'b1);
        idle(8);
        chk("shift_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("shift_data4",  cap[0].d4, -2);
            chk("shift_data32", cap[0].d32, -21);
        end

        // reset aborts a partial group
        cap.delete();
        step(10, 10, 1'b1, 1'b0);
        step(10, 10, 1'b1, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        step(1, 1, 1'b1, 1'b1);
        idle(8);
        chk("abort_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("abort_data", cap[0].d32, 1);
            chk("abort_cnt",  cap[0].c32, 1);
        end

        // beat counter saturation
        cap.delete();
        for (int i = 0; i < 299; i++) step(1, 1, 1'b1, 1'b0);
        step(1, 1, 1'b1, 1'b1);
        idle(8);
        chk("long_n", cap.size(), 1);
        if (cap.size() > 0) begin
            chk("long_data", cap[0].d32, 300);
            chk("long_cnt",  cap[0].c32, 255);
        end

        // randomized traffic with ce gaps and occasional resets
        for (int i = 0; i < 2500; i++) begin
            ce    = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step(int'($urandom_range(0, 65535)), int'($urandom_range(0, 16383)),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0);
        end
        reset = 1'b0;
        ce    = 1'b1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
